// File: rtl/instr_fetch_mem.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_mem
// Purpose  : Instruction memory with a valid/ready fetch port and a
//            program-load write port. Responses come back one cycle after a
//            request is accepted. A misaligned or out-of-range fetch returns
//            NOP_WORD and raises fault. The load port has priority over
//            fetches, and its contents are kept across reset.
// Ports    : clk        - rising-edge clock
//            rst_n      - asynchronous active-low reset
//            en         - block enable; 0 blocks new fetches
//            req_valid  - fetch request present
//            req_ready  - fetch can be accepted this cycle
//            address    - byte address of the fetch
//            resp_valid - inst_out/fault hold a valid response
//            resp_ready - consumer takes the response
//            inst_out   - fetched instruction
//            fault      - response is a misaligned/out-of-range fetch
//            load_en    - program-load write strobe
//            load_addr  - byte address of the load word
//            load_data  - word to write
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_mem #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 64,
    parameter logic [XLEN-1:0] NOP_WORD = XLEN'(32'h00000013)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     address,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] inst_out,
    output logic            fault,
    input  logic            load_en,
    input  logic [31:0]     load_addr,
    input  logic [XLEN-1:0] load_data
);

    localparam int unsigned c_IDX_W = $clog2(DEPTH);

    logic [XLEN-1:0]    r_mem [DEPTH];
    logic               r_resp_valid;
    logic [XLEN-1:0]    r_inst;
    logic               r_fault;

    logic [c_IDX_W-1:0] w_fetch_idx;
    logic [c_IDX_W-1:0] w_load_idx;
    logic               w_fetch_fault;
    logic               w_load_in_range;
    logic               w_req_ready;
    logic               w_accept;
    logic               w_unused;

    assign w_fetch_idx = address[c_IDX_W+1:2];
    assign w_load_idx  = load_addr[c_IDX_W+1:2];

    // Any set bit above the index field means the word address is >= DEPTH.
    assign w_fetch_fault   = (address[1:0] != 2'b00) ||
                             (address[31:c_IDX_W+2] != '0);
    assign w_load_in_range = (load_addr[31:c_IDX_W+2] == '0);

    // Byte offset of a load word is irrelevant; the word is always aligned.
    assign w_unused = &{1'b0, load_addr[1:0]};

    // A slot frees up either when nothing is held or when the held response
    // is consumed on this same edge, which allows one fetch per cycle.
    assign w_req_ready = en && !load_en && (!r_resp_valid || resp_ready);
    assign w_accept    = req_valid && w_req_ready;

    // Program storage has no reset so a loaded program survives rst_n.
    always_ff @(posedge clk) begin
        if (load_en && w_load_in_range) begin
            r_mem[w_load_idx] <= load_data;
        end
    end

    // Response register. Load and fetch never share a cycle, so the read
    // below always sees the contents as of the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_inst       <= '0;
            r_fault      <= 1'b0;
        end else if (w_accept) begin
            r_resp_valid <= 1'b1;
            r_fault      <= w_fetch_fault;
            r_inst       <= w_fetch_fault ? NOP_WORD : r_mem[w_fetch_idx];
        end else if (r_resp_valid && resp_ready) begin
            // Data/fault are left as-is so the last response stays visible.
            r_resp_valid <= 1'b0;
        end
    end

    assign req_ready  = w_req_ready;
    assign resp_valid = r_resp_valid;
    assign inst_out   = r_inst;
    assign fault      = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_mem
// Purpose  : Self-checking bench for instr_fetch_mem. Expected responses are
//            computed from a bench-side memory model and queued when a fetch
//            is driven, then popped when the response is consumed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_mem;

    localparam int unsigned     XLEN  = 32;
    localparam int unsigned     DEPTH = 64;
    localparam int unsigned     IW    = $clog2(DEPTH);
    localparam logic [XLEN-1:0] NOP   = 32'h00000013;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     address;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] inst_out;
    logic            fault;
    logic            load_en;
    logic [31:0]     load_addr;
    logic [XLEN-1:0] load_data;

    int n_cmp;
    int n_err;

    logic [XLEN-1:0] exp_mem [DEPTH];
    logic [XLEN:0]   sb [$];

    instr_fetch_mem #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .NOP_WORD (NOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .address    (address),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .inst_out   (inst_out),
        .fault      (fault),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour of one fetch: {fault, instruction}.
    function automatic logic [XLEN:0] model_fetch(input logic [31:0] a);
        logic [IW-1:0] idx;
        idx = a[IW+1:2];
        if (a[1:0] != 2'b00 || (a >> 2) >= DEPTH) return {1'b1, NOP};
        return {1'b0, exp_mem[idx]};
    endfunction

    task automatic load_word(input logic [31:0] a, input logic [XLEN-1:0] d);
        logic [IW-1:0] idx;
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        idx = a[IW+1:2];
        if ((a >> 2) < DEPTH) exp_mem[idx] = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_cmp++;
        if (resp_valid !== 1'b0 || inst_out !== '0 || fault !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b inst=%h fault=%b, want 0/0/0",
                     resp_valid, inst_out, fault);
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_req_ready: got %b, want 1", req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic [XLEN:0] exp;
        resp_ready = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (c > 0) begin
                n_cmp++;
                if (resp_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_valid[%0d]: got %b, want 1", c, resp_valid);
                end
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_sb_empty[%0d]: got empty, want entry", c);
                end else begin
                    exp = sb.pop_front();
                    if ({fault, inst_out} !== exp) begin
                        n_err++;
                        $display("FAIL b2b_data[%0d]: got %b/%h, want %b/%h",
                                 c, fault, inst_out, exp[XLEN], exp[XLEN-1:0]);
                    end
                end
            end
            if (c < 4) begin
                req_valid = 1'b1;
                address   = 32'(4 * c);
                sb.push_back(model_fetch(address));
                #1;
                n_cmp++;
                if (req_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_ready[%0d]: got %b, want 1", c, req_ready);
                end
            end else begin
                req_valid = 1'b0;
            end
        end
        @(negedge clk);
        n_cmp++;
        if (resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_clear: got %b, want 0", resp_valid);
        end
    endtask

    // Last in-range word, then a misaligned and a just-out-of-range address.
    task automatic test_fault;
        logic [31:0]   addrs [3];
        logic [XLEN:0] exp;
        addrs[0] = 32'(4 * (DEPTH - 1));
        addrs[1] = 32'h6;
        addrs[2] = 32'(4 * DEPTH);
        resp_ready = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            if (c > 0) begin
                n_cmp++;
                if (resp_valid !== 1'b1 || sb.size() == 0) begin
                    n_err++;
                    $display("FAIL fault_valid[%0d]: got %b, want 1", c, resp_valid);
                end else begin
                    exp = sb.pop_front();
                    if ({fault, inst_out} !== exp) begin
                        n_err++;
                        $display("FAIL fault_data[%0d]: got %b/%h, want %b/%h",
                                 c, fault, inst_out, exp[XLEN], exp[XLEN-1:0]);
                    end
                end
            end
            if (c < 3) begin
                req_valid = 1'b1;
                address   = addrs[c];
                sb.push_back(model_fetch(address));
            end else begin
                req_valid = 1'b0;
            end
        end
    endtask

    task automatic test_stall;
        logic [XLEN:0] exp;
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        address    = 32'h4;
        sb.push_back(model_fetch(address));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            address = 32'h8;
            #1;
            n_cmp++;
            if (resp_valid !== 1'b1 || inst_out !== 32'h22222222 ||
                fault !== 1'b0 || req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got v=%b i=%h f=%b rdy=%b, want 1/22222222/0/0",
                         c, resp_valid, inst_out, fault, req_ready);
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stall_ready_release: got %b, want 1", req_ready);
        end
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL stall_sb_empty: got empty, want entry");
        end else begin
            exp = sb.pop_front();
            if ({fault, inst_out} !== exp) begin
                n_err++;
                $display("FAIL stall_data: got %b/%h, want %b/%h",
                         fault, inst_out, exp[XLEN], exp[XLEN-1:0]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (resp_valid !== 1'b0 || inst_out !== 32'h22222222) begin
            n_err++;
            $display("FAIL stall_drain: got v=%b i=%h, want 0/22222222",
                     resp_valid, inst_out);
        end
    endtask

    task automatic test_load_priority;
        logic [XLEN:0] exp;
        @(negedge clk);
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        address    = 32'h8;
        load_en    = 1'b1;
        load_addr  = 32'h8;
        load_data  = 32'hDEADBEEF;
        exp_mem[2] = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL load_blocks_ready: got %b, want 0", req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL load_no_fetch: got %b, want 0", resp_valid);
        end
        load_en = 1'b0;
        sb.push_back(model_fetch(address));
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++;
        if (resp_valid !== 1'b1 || sb.size() == 0) begin
            n_err++;
            $display("FAIL load_fetch_valid: got %b, want 1", resp_valid);
        end else begin
            exp = sb.pop_front();
            if ({fault, inst_out} !== exp) begin
                n_err++;
                $display("FAIL load_fetch_data: got %b/%h, want %b/%h",
                         fault, inst_out, exp[XLEN], exp[XLEN-1:0]);
            end
        end
    endtask

    task automatic test_reset_midflight;
        logic [XLEN:0] exp;
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        address    = 32'h4;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_cmp++;
        if (resp_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midflight_pending: got %b, want 1", resp_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (resp_valid !== 1'b0 || inst_out !== '0 || fault !== 1'b0) begin
            n_err++;
            $display("FAIL midflight_async_clear: got v=%b i=%h f=%b, want 0/0/0",
                     resp_valid, inst_out, fault);
        end
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        address    = 32'h0;
        sb.push_back(model_fetch(address));
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++;
        if (resp_valid !== 1'b1 || sb.size() == 0) begin
            n_err++;
            $display("FAIL post_reset_fetch_valid: got %b, want 1", resp_valid);
        end else begin
            exp = sb.pop_front();
            if ({fault, inst_out} !== exp) begin
                n_err++;
                $display("FAIL post_reset_fetch_data: got %b/%h, want %b/%h",
                         fault, inst_out, exp[XLEN], exp[XLEN-1:0]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_stray: got %b, want 0", resp_valid);
        end
    endtask

    task automatic test_enable;
        logic [XLEN:0] exp;
        // A held response must still drain once en drops.
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        address    = 32'hC;
        sb.push_back(model_fetch(address));
        @(negedge clk);
        en         = 1'b0;
        resp_ready = 1'b1;
        n_cmp++;
        if (resp_valid !== 1'b1 || sb.size() == 0) begin
            n_err++;
            $display("FAIL en_drain_valid: got %b, want 1", resp_valid);
        end else begin
            exp = sb.pop_front();
            if ({fault, inst_out} !== exp) begin
                n_err++;
                $display("FAIL en_drain_data: got %b/%h, want %b/%h",
                         fault, inst_out, exp[XLEN], exp[XLEN-1:0]);
            end
        end
        address = 32'h4;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
                n_err++;
                $display("FAIL en_blocked[%0d]: got rdy=%b v=%b, want 0/0",
                         c, req_ready, resp_valid);
            end
        end
        en = 1'b1;
        sb.push_back(model_fetch(address));
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL en_ready: got %b, want 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++;
        if (resp_valid !== 1'b1 || sb.size() == 0) begin
            n_err++;
            $display("FAIL en_fetch_valid: got %b, want 1", resp_valid);
        end else begin
            exp = sb.pop_front();
            if ({fault, inst_out} !== exp) begin
                n_err++;
                $display("FAIL en_fetch_data: got %b/%h, want %b/%h",
                         fault, inst_out, exp[XLEN], exp[XLEN-1:0]);
            end
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        en         = 1'b1;
        req_valid  = 1'b0;
        address    = '0;
        resp_ready = 1'b1;
        load_en    = 1'b0;
        load_addr  = '0;
        load_data  = '0;

        test_reset();
        load_word(32'h0, 32'h11111111);
        load_word(32'h4, 32'h22222222);
        load_word(32'h8, 32'h33333333);
        load_word(32'hC, 32'h44444444);
        load_word(32'(4 * (DEPTH - 1)), 32'h63636363);
        test_back_to_back();
        test_fault();
        test_stall();
        test_load_priority();
        // Out-of-range load must be discarded (would alias onto word 0).
        load_word(32'(4 * DEPTH), 32'hBADBAD00);
        test_reset_midflight();
        // Byte offset of a load address is ignored (lands on word 3).
        load_word(32'hE, 32'h4444AAAA);
        test_enable();

        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d entries, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 SHALL have parameter XLEN, default 32, instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, number of instruction words; power of two, 2..4096.
REQ-003 SHALL have parameter NOP_WORD, default 32'h00000013, word returned on a faulted fetch.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port en  input  1  block enable; 0 blocks new fetches.
REQ-007 SHALL have port req_valid  input  1  fetch request present.
REQ-008 SHALL have port req_ready  output  1  fetch request can be accepted this cycle.
REQ-009 SHALL have port address  input  32  byte address of the fetch.
REQ-010 SHALL have port resp_valid  output  1  inst_out/fault hold a valid response.
REQ-011 SHALL have port resp_ready  input  1  consumer takes the response.
REQ-012 SHALL have port inst_out  output  XLEN  fetched instruction.
REQ-013 SHALL have port fault  output  1  response is a misaligned or out-of-range fetch.
REQ-014 SHALL have port load_en  input  1  program-load write strobe.
REQ-015 SHALL have port load_addr  input  32  byte address of the load word.
REQ-016 SHALL have port load_data  input  XLEN  word to write.

Function
REQ-017 SHALL hold DEPTH words of XLEN bits; word index = address[$clog2(DEPTH)+1:2].
REQ-018 SHALL drive req_ready = en && !load_en && (!resp_valid || resp_ready), combinationally.
REQ-019 SHALL accept a fetch on a rising edge where req_valid && req_ready; no other cycle accepts.
REQ-020 SHALL present the response exactly one cycle after acceptance (resp_valid=1 on the next edge).
REQ-021 SHALL sustain one fetch per cycle when resp_ready is held 1 (back-to-back, no bubbles).
REQ-022 SHALL hold inst_out, fault, resp_valid stable while resp_valid && !resp_ready.
REQ-023 SHALL clear resp_valid on an edge where resp_valid && resp_ready and no new fetch is accepted.
REQ-024 SHALL flag fault=1, inst_out=NOP_WORD when address[1:0]!=0 or (address>>2) >= DEPTH; else fault=0, inst_out=mem[index].
REQ-025 SHALL return data from the accepted-cycle memory contents (read before any later load).
REQ-026 SHALL write load_data to mem[load_addr word index] on an edge with load_en=1, ignoring load_addr[1:0]; writes with (load_addr>>2) >= DEPTH are discarded.
REQ-027 SHALL give load priority: load_en=1 forces req_ready=0, so fetch and load never share a cycle.
REQ-028 SHALL let a pending response drain while en=0 or load_en=1 (resp_ready still honoured).
REQ-029 SHALL keep inst_out and fault unchanged when resp_valid=0 after a drain (last value retained).

Reset
REQ-030 SHALL on rst_n=0, asynchronously: resp_valid=0, inst_out=0, fault=0; req_ready follows REQ-018.
REQ-031 SHALL drop any pending or in-flight response when reset asserts mid-operation; no response appears after release for a pre-reset fetch.
REQ-032 SHALL NOT reset memory contents; loaded program survives rst_n.
REQ-033 SHALL accept a fetch on the first edge after rst_n deasserts, if req_valid && req_ready.

Verification
REQ-034 Load mem[0..3]=0x11111111..0x44444444, fetch addresses 0,4,8,12 back-to-back with resp_ready=1 -> four responses on consecutive cycles, one cycle latency, correct words, fault=0.
REQ-035 Fetch address 0x6 and address 4*DEPTH (0x100 at default) -> fault=1, inst_out=0x00000013, for each.
REQ-036 Fetch addr 4 with resp_ready=0 for 3 cycles -> resp_valid=1, inst_out=0x22222222 stable, req_ready=0; resp_ready=1 -> response drains, req_ready=1.
REQ-037 Hold req_valid=1 while load_en=1 writes 0xDEADBEEF to addr 8 -> req_ready=0 that cycle; fetch of 8 next cycle returns 0xDEADBEEF.
REQ-038 Accept fetch, assert rst_n=0 before the next edge, release -> resp_valid=0 immediately and stays 0; mem[0] still 0x11111111 on refetch.
REQ-039 en=0 with req_valid=1 for 4 cycles -> req_ready=0, no response; en=1 -> fetch accepted next edge.
